// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA row prefetch cache.
// Frame-buffer geometry and the fetch FSM encoding live here.
package vga_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    COMMIT = 2'd2
  } fetch_state_t;

  localparam int          VGA_WORDS_PER_ROW = 4;
  localparam int          VGA_ROWS          = 96;
  localparam logic [31:0] VGA_FB_BASE       = 32'h3E80;

endpackage

// File: rtl/vga_lb_bank.sv
// One row bank: 4x32 data words, a 7-bit row tag and a valid bit.
// Write port is synchronous, read port is combinational.
module vga_lb_bank
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic        nrst,
  input  logic        i_clr,
  input  logic        i_start,
  input  logic [6:0]  i_tag,
  input  logic        i_set,
  input  logic        i_we,
  input  logic [1:0]  i_waddr,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_raddr,
  output logic [31:0] o_rdata,
  output logic [6:0]  o_tag,
  output logic        o_valid
);

  logic [31:0] r_mem [VGA_WORDS_PER_ROW];
  logic [6:0]  r_tag;
  logic        r_valid;

  // Clearing wins over set so a frame start cancels a commit.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      for (int i = 0; i < VGA_WORDS_PER_ROW; i++)
        r_mem[i] <= '0;
    end else begin
      if (i_clr || i_start)
        r_valid <= 1'b0;
      else if (i_set)
        r_valid <= 1'b1;
      if (i_start)
        r_tag <= i_tag;
      if (i_we)
        r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];
  assign o_tag   = r_tag;
  assign o_valid = r_valid;

endmodule

// File: rtl/vga_line_prefetch.sv
// Double-buffered row cache feeding VGA_out from a req/ack SRAM bus.
// Define VGA_LB_STATS_EN to add the saturating underrun_cnt output.
module vga_line_prefetch
  import vga_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = VGA_FB_BASE,
  parameter int          ROWS      = VGA_ROWS
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [1:0]  vga_state,
  input  logic        vga_data_en,
  input  logic [31:0] vga_addr,
  output logic [31:0] vga_data,
  output logic        vga_busy,
  input  logic        grant,
  output logic        bus_req,
  output logic [31:0] bus_addr,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
`ifdef VGA_LB_STATS_EN
  ,
  output logic [15:0] underrun_cnt
`endif
);

  localparam logic [31:0] ROWS_U = 32'(ROWS);

  fetch_state_t r_state;
  logic [6:0]   r_tgt;
  logic [1:0]   r_widx;
  logic [6:0]   r_disp;
  logic [1:0]   r_prev_vs;

  logic [31:0] w_off;
  logic [6:0]  w_row;
  logic [1:0]  w_word;
  logic        w_hit;
  logic        w_unused;
  logic [1:0]  w_valid;
  logic [6:0]  w_tag [2];
  logic [31:0] w_rd  [2];

  assign w_off    = vga_addr - BASE_ADDR;
  assign w_row    = w_off[8:2];
  assign w_word   = w_off[1:0];
  assign w_unused = ^w_off[31:9];

  assign w_hit = vga_data_en
               & w_valid[w_row[0]]
               & (w_tag[w_row[0]] == w_row);

  assign vga_data = w_hit ? w_rd[w_row[0]] : '0;
  assign vga_busy = vga_data_en & ~w_hit;

  logic w_fs;
  assign w_fs = (vga_state == 2'd1)
              & (r_prev_vs != 2'd1);

  logic [7:0] w_nxt8;
  logic       w_cur_ok;
  logic       w_nxt_ok;
  logic       w_res_cur;
  logic       w_res_nxt;

  assign w_nxt8    = {1'b0, r_disp} + 8'd1;
  assign w_cur_ok  = {25'd0, r_disp} < ROWS_U;
  assign w_nxt_ok  = {24'd0, w_nxt8} < ROWS_U;
  assign w_res_cur = w_valid[r_disp[0]]
                   & (w_tag[r_disp[0]] == r_disp);
  assign w_res_nxt = w_valid[w_nxt8[0]]
                   & (w_tag[w_nxt8[0]] == w_nxt8[6:0]);

  logic       w_go;
  logic [6:0] w_sel;

  // Current display row first, then the one after it.
  always_comb begin
    w_go  = 1'b0;
    w_sel = r_disp;
    unique case (1'b1)
      (w_cur_ok & ~w_res_cur): begin
        w_go  = 1'b1;
        w_sel = r_disp;
      end
      (w_cur_ok & w_res_cur & w_nxt_ok & ~w_res_nxt): begin
        w_go  = 1'b1;
        w_sel = w_nxt8[6:0];
      end
      default: ;
    endcase
  end

  logic       w_idle_go;
  logic       w_ack;
  logic       w_last;
  logic       w_commit;
  logic [1:0] w_widx_inc;

  assign w_idle_go  = (r_state == IDLE) & w_go & ~w_fs;
  assign w_ack      = (r_state == REQ) & bus_ack
                    & grant & ~w_fs;
  assign w_last     = w_ack & (r_widx == 2'd3);
  assign w_commit   = (r_state == COMMIT) & ~w_fs;
  assign w_widx_inc = r_widx + 2'd1;

  assign bus_req = (r_state == REQ) & grant;

  for (genvar k = 0; k < 2; k++) begin : g_bank
    vga_lb_bank u_bank (
      .clk     (clk),
      .nrst    (nrst),
      .i_clr   (w_fs),
      .i_start (w_idle_go & (w_sel[0] == 1'(k))),
      .i_tag   (w_sel),
      .i_set   (w_commit & (r_tgt[0] == 1'(k))),
      .i_we    (w_ack & (r_tgt[0] == 1'(k))),
      .i_waddr (r_widx),
      .i_wdata (bus_rdata),
      .i_raddr (w_word),
      .o_rdata (w_rd[k]),
      .o_tag   (w_tag[k]),
      .o_valid (w_valid[k])
    );
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= IDLE;
    end else if (w_fs) begin
      r_state <= IDLE;
    end else begin
      unique case (r_state)
        IDLE:    if (w_go) r_state <= REQ;
        REQ:     if (w_last) r_state <= COMMIT;
        COMMIT:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_tgt    <= '0;
      r_widx   <= '0;
      bus_addr <= '0;
    end else if (w_idle_go) begin
      r_tgt    <= w_sel;
      r_widx   <= '0;
      bus_addr <= BASE_ADDR
                + {23'd0, w_sel, 2'b00};
    end else if (w_ack) begin
      r_widx   <= w_widx_inc;
      bus_addr <= BASE_ADDR
                + {23'd0, r_tgt, w_widx_inc};
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_disp    <= '0;
      r_prev_vs <= '0;
    end else begin
      r_prev_vs <= vga_state;
      if (w_fs)
        r_disp <= '0;
      else if (vga_data_en && (w_row != r_disp))
        r_disp <= w_row;
    end
  end

`ifdef VGA_LB_STATS_EN
  logic [15:0] r_underrun;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)
      r_underrun <= '0;
    else if (vga_busy && (r_underrun != 16'hFFFF))
      r_underrun <= r_underrun + 16'd1;
  end

  assign underrun_cnt = r_underrun;
`endif

endmodule

// File: tb/tb_vga_line_prefetch.sv
// Bench for vga_line_prefetch: directed row-fill scenarios, then
// random traffic against a row-residency reference model.
module tb_vga_line_prefetch;

  localparam logic [31:0] BASE  = 32'h3E80;
  localparam int          NROWS = 96;
  localparam logic [31:0] PAT   = 32'h5A5A0000;

  logic        clk = 1'b0;
  logic        nrst;
  logic [1:0]  vga_state;
  logic        vga_data_en;
  logic [31:0] vga_addr;
  logic [31:0] vga_data;
  logic        vga_busy;
  logic        grant;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic        bus_ack;
  logic [31:0] bus_rdata;
`ifdef VGA_LB_STATS_EN
  logic [15:0] underrun_cnt;
`endif

  vga_line_prefetch #(
    .BASE_ADDR (BASE),
    .ROWS      (NROWS)
  ) dut (
    .clk         (clk),
    .nrst        (nrst),
    .vga_state   (vga_state),
    .vga_data_en (vga_data_en),
    .vga_addr    (vga_addr),
    .vga_data    (vga_data),
    .vga_busy    (vga_busy),
    .grant       (grant),
    .bus_req     (bus_req),
    .bus_addr    (bus_addr),
    .bus_ack     (bus_ack),
    .bus_rdata   (bus_rdata)
`ifdef VGA_LB_STATS_EN
    ,
    .underrun_cnt (underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference model: which row each bank holds and the fill in flight.
  logic        mv [2];
  logic [6:0]  mt [2];
  logic [31:0] md [2][4];
  logic [6:0]  mdisp;
  logic [1:0]  mprev;
  int          fph;
  logic [6:0]  frow;
  int          fcnt;
  logic [31:0] maddr;

  logic        m_fs;
  logic [31:0] m_off;
  logic [6:0]  m_row;
  logic [6:0]  m_d0;
  int          m_nxt;

  function automatic logic resident(input logic [6:0] r);
    return mv[r[0]] && (mt[r[0]] == r);
  endfunction

  task automatic m_start(input logic [6:0] r);
    mv[r[0]] = 1'b0;
    mt[r[0]] = r;
    frow     = r;
    fcnt     = 0;
    fph      = 1;
    maddr    = BASE + {23'd0, r, 2'b00};
  endtask

  always @(posedge clk) begin
    if (!nrst) begin
      for (int b = 0; b < 2; b++) begin
        mv[b] = 1'b0;
        mt[b] = '0;
        for (int w = 0; w < 4; w++) md[b][w] = '0;
      end
      mdisp = '0;
      mprev = '0;
      fph   = 0;
      frow  = '0;
      fcnt  = 0;
      maddr = '0;
    end else begin
      m_fs  = (vga_state == 2'd1) && (mprev != 2'd1);
      m_d0  = mdisp;
      m_off = vga_addr - BASE;
      m_row = m_off[8:2];
      if (m_fs) begin
        mv[0] = 1'b0;
        mv[1] = 1'b0;
        mdisp = '0;
        fph   = 0;
      end else begin
        if (vga_data_en && (m_row != mdisp)) mdisp = m_row;
        if (fph == 0) begin
          m_nxt = int'(m_d0) + 1;
          if (int'(m_d0) < NROWS && !resident(m_d0))
            m_start(m_d0);
          else if (m_nxt < NROWS && !resident(7'(m_nxt)))
            m_start(7'(m_nxt));
        end else if (fph == 1) begin
          if (bus_ack && grant) begin
            md[frow[0]][fcnt] = bus_rdata;
            fcnt++;
            maddr = BASE + {23'd0, frow, 2'(fcnt % 4)};
            if (fcnt == 4) fph = 2;
          end
        end else begin
          mv[frow[0]] = 1'b1;
          fph = 0;
        end
      end
      mprev = vga_state;
    end
  end

  // Bus slave: directed mode acks one cycle after req, random otherwise.
  int   ack_mode = 0;
  logic prev_rq  = 1'b0;
  logic r_rq;
  logic r_a;

  always @(posedge clk) begin
    #2;
    r_rq = (fph == 1) && grant && nrst;
    if (ack_mode == 0)
      r_a = r_rq && prev_rq && !bus_ack;
    else
      r_a = r_rq && ($urandom_range(0, 2) == 0);
    bus_ack   = r_a;
    bus_rdata = (ack_mode == 0) ? (maddr ^ PAT) : $urandom;
    prev_rq   = r_rq;
  end

  // Per-cycle compare against the model; also logs accepted reads.
  logic        run_chk = 1'b0;
  logic [31:0] q_ack [$];
  int          nreq = 0;
  logic [31:0] c_off;
  logic [6:0]  c_row;
  logic        c_hit;

  always @(negedge clk) begin
    if (nrst && run_chk) begin
      c_off = vga_addr - BASE;
      c_row = c_off[8:2];
      c_hit = vga_data_en && resident(c_row);
      chk("vga_data", vga_data,
          c_hit ? md[c_row[0]][c_off[1:0]] : 32'd0);
      chk("vga_busy", 32'(vga_busy),
          32'(vga_data_en && !c_hit));
      chk("bus_req", 32'(bus_req), 32'((fph == 1) && grant));
      chk("bus_addr", bus_addr, maddr);
      if (bus_req) nreq++;
      if (bus_req && bus_ack && grant) q_ack.push_back(bus_addr);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_acks(input int n);
    for (int i = 0; i < 400 && q_ack.size() < n; i++)
      @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] qa(input int i);
    return (i < q_ack.size()) ? q_ack[i] : 32'hFFFF_FFFF;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  int r;

  initial begin
    nrst        = 1'b0;
    vga_state   = 2'd0;
    vga_data_en = 1'b0;
    vga_addr    = BASE;
    grant       = 1'b0;
    bus_ack     = 1'b0;
    bus_rdata   = '0;
    repeat (2) @(negedge clk);
    chk("rst bus_req", 32'(bus_req), 32'd0);
    chk("rst bus_addr", bus_addr, 32'd0);
    chk("rst vga_data", vga_data, 32'd0);
    chk("rst vga_busy", 32'(vga_busy), 32'd0);
    @(posedge clk);
    #1;
    nrst    = 1'b1;
    run_chk = 1'b1;

`ifdef VGA_LB_STATS_EN
    vga_data_en = 1'b1;
    tick(5);
    vga_data_en = 1'b0;
    @(negedge clk);
    chk("underrun_cnt", 32'(underrun_cnt), 32'd5);
    tick(1);
`endif

    // Frame start, then rows 0 and 1 with a permanent grant.
    vga_state = 2'd1;
    tick(1);
    q_ack.delete();
    vga_state = 2'd2;
    grant     = 1'b1;
    wait_acks(8);
    tick(2);
    nreq = 0;
    tick(30);
    chk("rows01 count", q_ack.size(), 32'd8);
    for (int i = 0; i < 8; i++)
      chk("rows01 addr", qa(i), BASE + 32'(i));
    chk("idle no req", nreq, 32'd0);

    vga_addr    = 32'h3E82;
    vga_data_en = 1'b1;
    @(negedge clk);
    chk("row0 w2 data", vga_data, 32'h5A5A3E82);
    chk("row0 w2 busy", 32'(vga_busy), 32'd0);

    // Row 1 request prefetches row 2; grant gap after the 2nd word.
    tick(1);
    q_ack.delete();
    vga_addr = 32'h3E84;
    for (int i = 0; i < 400 && q_ack.size() < 2; i++)
      @(posedge clk);
    #1;
    grant = 1'b0;
    nreq  = 0;
    tick(10);
    vga_addr = 32'h3E80;
    @(negedge clk);
    chk("bank0 miss busy", 32'(vga_busy), 32'd1);
    chk("bank0 miss data", vga_data, 32'd0);
    tick(1);
    vga_addr = 32'h3E84;
    tick(9);
    chk("gap no req", nreq, 32'd0);
    grant = 1'b1;
    wait_acks(4);
    tick(30);
    chk("row2 count", q_ack.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("row2 addr", qa(i), 32'h3E88 + 32'(i));

    // Last displayed row: fetch row 95, never row 96.
    q_ack.delete();
    vga_addr = 32'h3FFC;
    wait_acks(4);
    tick(1);
    nreq = 0;
    tick(30);
    chk("row95 count", q_ack.size(), 32'd4);
    chk("row95 first", qa(0), 32'h3FFC);
    chk("row95 last", qa(3), 32'h3FFF);
    chk("no row96 req", nreq, 32'd0);
    vga_addr = 32'h3FFE;
    @(negedge clk);
    chk("row95 data", vga_data, 32'h5A5A3FFE);

    // Frame start in the middle of a far-row fill.
    tick(1);
    q_ack.delete();
    vga_addr = 32'h3F48;
    wait_acks(1);
    chk("far row addr", qa(0), 32'h3F48);
    vga_state   = 2'd1;
    vga_data_en = 1'b0;
    tick(1);
    q_ack.delete();
    vga_state = 2'd2;
    wait_acks(1);
    chk("abort restart", qa(0), 32'h3E80);

    // Random traffic.
    ack_mode = 1;
    for (int c = 0; c < 4000; c++) begin
      tick(1);
      if ($urandom_range(0, 9) == 0) grant = ~grant;
      r = $urandom_range(0, 999);
      vga_state = (r < 3) ? 2'd1 : (r < 6) ? 2'd0 : 2'd2;
      vga_data_en = ($urandom_range(0, 9) < 7);
      r = $urandom_range(0, 99);
      if (r < 60)
        vga_addr = BASE + {23'd0, mdisp, 2'($urandom)};
      else if (r < 80)
        vga_addr = BASE + {23'd0, mdisp + 7'd1, 2'($urandom)};
      else if (r < 97)
        vga_addr = BASE + 32'($urandom_range(0, 99) * 4)
                 + 32'($urandom_range(0, 3));
      else
        vga_addr = $urandom;
    end

    tick(2);
    run_chk = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
